// File: rtl/squeeze_unit_pkg.sv
// Keccak squeeze-side constants, state/beat types and FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: sponge geometry (5x5x64 state), 256-bit beat geometry, squeeze FSM states.
package squeeze_unit_pkg;

  localparam int DWIDTH            = 256;
  localparam int KEEP_WIDTH        = DWIDTH / 8;
  localparam int LANE_SIZE         = 64;
  localparam int ROW_SIZE          = 5;
  localparam int COL_SIZE          = 5;
  localparam int RATE_WIDTH        = 11;   // holds 1344, the widest rate
  localparam int BYTE_ABSORB_WIDTH = 8;    // byte offset within one rate block
  localparam int LANES_PER_BEAT    = 4;
  localparam int MAX_RATE_LANES    = 21;
  localparam int LANE_IDX_WIDTH    = 5;    // enough for MAX_RATE_LANES

  // state[x][y], lane x+5y is linear lane L
  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;
  typedef logic [LANES_PER_BEAT-1:0][LANE_SIZE-1:0]         beat_lanes_t;

  typedef enum logic [1:0] {
    SQZ_IDLE,
    SQZ_EMIT,
    SQZ_PERM_WAIT
  } squeeze_state_e;

  // Contiguous byte enables from bit 0 for n bytes (n = 0..32).
  function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [5:0] n);
    if (n[5]) return '1;
    return (KEEP_WIDTH'(1) << n[4:0]) - KEEP_WIDTH'(1);
  endfunction

endpackage

// File: rtl/squeeze_unit_if.sv
// Output byte stream of the squeeze unit: 256-bit data with byte keep, valid/ready.
// Latency: n/a (wires only).
// Backpressure: master holds data_o/keep_o/last_o while valid_o && !ready_i.
// Modports: master (squeeze_unit drives beats), slave (digest/XOF sink).
interface squeeze_unit_if import squeeze_unit_pkg::*; ();
  logic [DWIDTH-1:0]     data_o;
  logic [KEEP_WIDTH-1:0] keep_o;
  logic                  valid_o;
  logic                  last_o;
  logic                  ready_i;

  modport master (output data_o, keep_o, valid_o, last_o, input ready_i);
  modport slave  (input data_o, keep_o, valid_o, last_o, output ready_i);
endinterface

// File: rtl/squeeze_unit_lane_select.sv
// Picks four consecutive rate lanes out of the sponge state, starting at start_lane.
// Latency: purely combinational.
// Backpressure: none.
// Ports: state (5x5x64), start_lane, lane_limit (rate/64) -> lanes[0..3]; lanes past the limit read as zero.
module squeeze_unit_lane_select import squeeze_unit_pkg::*; (
  input  state_t                    state,
  input  logic [LANE_IDX_WIDTH-1:0] start_lane,
  input  logic [LANE_IDX_WIDTH-1:0] lane_limit,
  output beat_lanes_t               lanes
);

  logic [LANE_IDX_WIDTH:0] lin;

  always_comb begin
    lanes = '0;
    lin   = '0;
    for (int j = 0; j < LANES_PER_BEAT; j++) begin
      lin = {1'b0, start_lane} + (LANE_IDX_WIDTH+1)'(j);
      // lane_limit <= 21 keeps lin < 25, so x/y stay inside the 5x5 grid
      if (lin < {1'b0, lane_limit})
        lanes[j] = state[3'(lin % 6'd5)][3'(lin / 6'd5)];
    end
  end

endmodule

// File: rtl/squeeze_unit.sv
// Squeeze side of the Keccak sponge: streams up to out_len bytes from permuted states, asking for more permutations.
// Latency: first beat valid 1 cycle after start_i; 1 beat/cycle while ready_i is high; done_o 1 cycle after the last beat.
// Backpressure: beat held stable while valid_o && !ready_i; state/offset only advance on handshake.
// Ports: clk, rst (sync, active high), start_i/rate_i/out_len_i/state_array_i, perm_req_o/perm_done_i,
//        out (squeeze_unit_if.master byte stream), busy_o, done_o.
// Build option SQUEEZE_PACK_EN: block-tail lanes are carried across the permutation so every non-last beat is full.
module squeeze_unit import squeeze_unit_pkg::*; #(
  parameter int OUT_LEN_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [RATE_WIDTH-1:0]    rate_i,
  input  logic [OUT_LEN_WIDTH-1:0] out_len_i,
  input  state_t                   state_array_i,
  output logic                     perm_req_o,
  input  logic                     perm_done_i,
  squeeze_unit_if.master           out,
  output logic                     busy_o,
  output logic                     done_o
);

  squeeze_state_e                st_q, st_d;
  state_t                        state_q;
  logic [LANE_IDX_WIDTH-1:0]     rate_lanes_q;
  logic [BYTE_ABSORB_WIDTH-1:0]  blk_off_q;
  logic [OUT_LEN_WIDTH-1:0]      rem_q;
  logic                          done_q;

  beat_lanes_t                   sel_lanes, beat;
  logic [BYTE_ABSORB_WIDTH-1:0]  rate_bytes, avail, blk_next;
  logic [OUT_LEN_WIDTH-1:0]      cap;
  logic [5:0]                    nbytes;
  logic [4:0]                    carry_bytes;
  logic                          carry_take, hs, last_w;
  logic [KEEP_WIDTH-1:0]         keep_w;
  logic [DWIDTH-1:0]             beat_flat, data_w;
  logic                          rate_unused;

`ifdef SQUEEZE_PACK_EN
  beat_lanes_t                   carry_q;
  logic [1:0]                    carry_cnt_q;
`endif

  // rate is a multiple of 64 bits, so only the lane count matters
  assign rate_unused = ^rate_i[5:0];
  assign rate_bytes  = {rate_lanes_q, 3'b000};
  assign avail       = rate_bytes - blk_off_q;

  squeeze_unit_lane_select u_sel (
    .state      (state_q),
    .start_lane (blk_off_q[BYTE_ABSORB_WIDTH-1:3]),
    .lane_limit (rate_lanes_q),
    .lanes      (sel_lanes)
  );

  // Beat assembly and byte count
  always_comb begin
    beat        = sel_lanes;
    carry_take  = 1'b0;
    carry_bytes = '0;
`ifdef SQUEEZE_PACK_EN
    carry_bytes = {carry_cnt_q, 3'b000};
    for (int j = 0; j < LANES_PER_BEAT; j++)
      beat[j] = (2'(j) < carry_cnt_q) ? carry_q[j] : sel_lanes[2'(j) - carry_cnt_q];
    // short block tail with more output pending: park it instead of emitting a short beat
    carry_take = (st_q == SQZ_EMIT) && (carry_cnt_q == 2'd0) && (avail < 8'd32) &&
                 (rem_q > OUT_LEN_WIDTH'(avail));
`endif
    cap = OUT_LEN_WIDTH'(avail) + OUT_LEN_WIDTH'(carry_bytes);
    if (cap > OUT_LEN_WIDTH'(32)) cap = OUT_LEN_WIDTH'(32);
    if (rem_q < cap) cap = rem_q;
    nbytes   = cap[5:0];
    keep_w   = keep_mask(nbytes);
    last_w   = (OUT_LEN_WIDTH'(nbytes) == rem_q);
    blk_next = blk_off_q + BYTE_ABSORB_WIDTH'(nbytes) - BYTE_ABSORB_WIDTH'(carry_bytes);
    beat_flat = beat;
    data_w    = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      data_w[8*i +: 8] = keep_w[i] ? beat_flat[8*i +: 8] : 8'h00;
  end

  assign hs = out.valid_o && out.ready_i;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) st_q <= SQZ_IDLE;
    else     st_q <= st_d;
  end

  // FSM next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      SQZ_IDLE:
        if (start_i && (out_len_i != '0)) st_d = SQZ_EMIT;
      SQZ_EMIT:
        if (carry_take)                     st_d = SQZ_PERM_WAIT;
        else if (hs && last_w)              st_d = SQZ_IDLE;
        else if (hs && blk_next == rate_bytes) st_d = SQZ_PERM_WAIT;
      SQZ_PERM_WAIT:
        if (perm_done_i) st_d = SQZ_EMIT;
      default: st_d = SQZ_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    out.valid_o = (st_q == SQZ_EMIT) && !carry_take;
    out.data_o  = out.valid_o ? data_w : '0;
    out.keep_o  = out.valid_o ? keep_w : '0;
    out.last_o  = out.valid_o && last_w;
    perm_req_o  = (st_q == SQZ_PERM_WAIT);
    busy_o      = (st_q != SQZ_IDLE);
    done_o      = done_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= '0;
      rate_lanes_q <= '0;
      blk_off_q    <= '0;
      rem_q        <= '0;
      done_q       <= 1'b0;
`ifdef SQUEEZE_PACK_EN
      carry_q      <= '0;
      carry_cnt_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (st_q)
        SQZ_IDLE:
          if (start_i) begin
            state_q      <= state_array_i;
            rate_lanes_q <= rate_i[RATE_WIDTH-1:6];
            rem_q        <= out_len_i;
            blk_off_q    <= '0;
            done_q       <= (out_len_i == '0);
          end
        SQZ_EMIT: begin
`ifdef SQUEEZE_PACK_EN
          if (carry_take) begin
            carry_q     <= sel_lanes;
            carry_cnt_q <= avail[4:3];
            blk_off_q   <= '0;
          end else
`endif
          if (hs) begin
            rem_q     <= rem_q - OUT_LEN_WIDTH'(nbytes);
            blk_off_q <= (blk_next == rate_bytes) ? '0 : blk_next;
            done_q    <= last_w;
`ifdef SQUEEZE_PACK_EN
            carry_cnt_q <= '0;
`endif
          end
        end
        SQZ_PERM_WAIT:
          if (perm_done_i) state_q <= state_array_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_squeeze_unit.sv
// Directed bench for squeeze_unit: reset, single/multi-block squeeze, backpressure, zero length, short tail, reset in PERM_WAIT.
// Latency: n/a.
// Backpressure: ready_i driven by the bench, pulsed per beat or held low.
module tb_squeeze_unit;
  import squeeze_unit_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start_i = 1'b0;
  logic                  perm_done_i = 1'b0;
  logic [RATE_WIDTH-1:0] rate_i = '0;
  logic [15:0]           out_len_i = '0;
  state_t                state_array_i = '0;
  logic                  perm_req_o, busy_o, done_o;

  squeeze_unit_if sq_if ();

  squeeze_unit #(.OUT_LEN_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .rate_i        (rate_i),
    .out_len_i     (out_len_i),
    .state_array_i (state_array_i),
    .perm_req_o    (perm_req_o),
    .perm_done_i   (perm_done_i),
    .out           (sq_if),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int perm_seen = 0;
  int base;

  always @(posedge clk) if (perm_req_o) perm_seen <= perm_seen + 1;

  // Linear lane L of a state built from seed; every byte nonzero
  function automatic logic [63:0] lane(input int seed, input int l);
    return {8'(seed), 8'(l % 5 + 1), 8'(l / 5 + 1), 40'h0123456789};
  endfunction

  function automatic state_t mk_state(input int seed);
    state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = lane(seed, 5 * y + x);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_sq(input int rate, input int len, input int seed);
    rate_i        = RATE_WIDTH'(rate);
    out_len_i     = 16'(len);
    state_array_i = mk_state(seed);
    start_i       = 1'b1;
    @(negedge clk);
    start_i       = 1'b0;
    state_array_i = mk_state(99);
    chk("valid after start", sq_if.valid_o, (len != 0));
    chk("busy after start", busy_o, (len != 0));
    chk("done after start", done_o, (len == 0));
  endtask

  task automatic get_beat(input string tag, input logic [255:0] ed, input logic [31:0] ek, input logic el);
    int t;
    t = 0;
    while (!sq_if.valid_o && t < 40) begin @(negedge clk); t++; end
    chk({tag, ".valid"}, sq_if.valid_o, 1'b1);
    chk({tag, ".data"}, sq_if.data_o, ed);
    chk({tag, ".keep"}, sq_if.keep_o, ek);
    chk({tag, ".last"}, sq_if.last_o, el);
    sq_if.ready_i = 1'b1;
    @(negedge clk);
    sq_if.ready_i = 1'b0;
  endtask

  task automatic consume(input string tag, input int n);
    int t;
    for (int b = 0; b < n; b++) begin
      t = 0;
      while (!sq_if.valid_o && t < 40) begin @(negedge clk); t++; end
      chk($sformatf("%s beat%0d valid", tag, b), sq_if.valid_o, 1'b1);
      sq_if.ready_i = 1'b1;
      @(negedge clk);
      sq_if.ready_i = 1'b0;
    end
  endtask

  task automatic wait_req(input string tag);
    int t;
    t = 0;
    while (!perm_req_o && t < 40) begin @(negedge clk); t++; end
    chk({tag, ".perm_req"}, perm_req_o, 1'b1);
    chk({tag, ".valid in wait"}, sq_if.valid_o, 1'b0);
  endtask

  task automatic wait_perm(input string tag, input int seed);
    wait_req(tag);
    repeat (9) @(negedge clk);
    chk({tag, ".perm_req held"}, perm_req_o, 1'b1);
    state_array_i = mk_state(seed);
    perm_done_i   = 1'b1;
    @(negedge clk);
    perm_done_i   = 1'b0;
    state_array_i = mk_state(98);
    chk({tag, ".perm_req drop"}, perm_req_o, 1'b0);
  endtask

  initial begin
    logic [255:0] exp0;
    sq_if.ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst valid", sq_if.valid_o, 1'b0);
    chk("rst last", sq_if.last_o, 1'b0);
    chk("rst data", sq_if.data_o, '0);
    chk("rst keep", sq_if.keep_o, '0);
    chk("rst perm_req", perm_req_o, 1'b0);
    chk("rst busy", busy_o, 1'b0);
    chk("rst done", done_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // T1: single full beat
    base = perm_seen;
    start_sq(1088, 32, 1);
    get_beat("t1", {lane(1, 3), lane(1, 2), lane(1, 1), lane(1, 0)}, 32'hFFFF_FFFF, 1'b1);
    chk("t1 done", done_o, 1'b1);
    chk("t1 busy", busy_o, 1'b0);
    @(negedge clk);
    chk("t1 done pulse", done_o, 1'b0);
    chk("t1 no perm", 32'(perm_seen - base), 32'd0);

    // T2: 200 bytes at rate 1344 crosses one block boundary
    start_sq(1344, 200, 2);
    for (int b = 0; b < 5; b++)
      get_beat($sformatf("t2 beat%0d", b),
               {lane(2, 4*b+3), lane(2, 4*b+2), lane(2, 4*b+1), lane(2, 4*b)}, 32'hFFFF_FFFF, 1'b0);
`ifdef SQUEEZE_PACK_EN
    chk("t2p no short beat", sq_if.valid_o, 1'b0);
    wait_perm("t2p", 3);
    get_beat("t2p carry", {lane(3, 2), lane(3, 1), lane(3, 0), lane(2, 20)}, 32'hFFFF_FFFF, 1'b0);
    get_beat("t2p final", {192'h0, lane(3, 3)}, 32'h0000_00FF, 1'b1);
`else
    get_beat("t2 short", {192'h0, lane(2, 20)}, 32'h0000_00FF, 1'b0);
    wait_perm("t2", 3);
    get_beat("t2 final", {lane(3, 3), lane(3, 2), lane(3, 1), lane(3, 0)}, 32'hFFFF_FFFF, 1'b1);
`endif
    chk("t2 done", done_o, 1'b1);

    // T3: hold ready low on the first beat
    start_sq(1088, 64, 4);
    exp0 = {lane(4, 3), lane(4, 2), lane(4, 1), lane(4, 0)};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3 hold%0d valid", i), sq_if.valid_o, 1'b1);
      chk($sformatf("t3 hold%0d data", i), sq_if.data_o, exp0);
      chk($sformatf("t3 hold%0d keep", i), sq_if.keep_o, 32'hFFFF_FFFF);
      chk($sformatf("t3 hold%0d last", i), sq_if.last_o, 1'b0);
      @(negedge clk);
    end
    get_beat("t3 b0", exp0, 32'hFFFF_FFFF, 1'b0);
    get_beat("t3 b1", {lane(4, 7), lane(4, 6), lane(4, 5), lane(4, 4)}, 32'hFFFF_FFFF, 1'b1);

    // T4: zero-length request
    @(negedge clk);
    base = perm_seen;
    start_sq(1344, 0, 5);
    @(negedge clk);
    chk("t4 done pulse", done_o, 1'b0);
    chk("t4 valid", sq_if.valid_o, 1'b0);
    chk("t4 no perm", 32'(perm_seen - base), 32'd0);

    // T5: 5-byte squeeze at rate 576
    start_sq(576, 5, 5);
    get_beat("t5", {192'h0, lane(5, 0) & 64'h0000_00FF_FFFF_FFFF}, 32'h0000_001F, 1'b1);
    chk("t5 done", done_o, 1'b1);

    // T6: reset while waiting for a permutation, then restart
    start_sq(1344, 200, 6);
`ifdef SQUEEZE_PACK_EN
    consume("t6", 5);
`else
    consume("t6", 6);
`endif
    wait_req("t6");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6 rst perm_req", perm_req_o, 1'b0);
    chk("t6 rst busy", busy_o, 1'b0);
    chk("t6 rst valid", sq_if.valid_o, 1'b0);
    chk("t6 rst done", done_o, 1'b0);
    chk("t6 rst data", sq_if.data_o, '0);
    chk("t6 rst keep", sq_if.keep_o, '0);
    perm_done_i = 1'b1;
    @(negedge clk);
    perm_done_i = 1'b0;
    chk("t6 stray perm_done", sq_if.valid_o, 1'b0);
    start_sq(1088, 32, 7);
    get_beat("t6 restart", {lane(7, 3), lane(7, 2), lane(7, 1), lane(7, 0)}, 32'hFFFF_FFFF, 1'b1);
    chk("t6 restart done", done_o, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
